boot_loader_sequencer: RTL and testbench

- Sequences program loading over UART before the pipeline runs: parses a framed byte stream, writes 32-bit words into instruction memory, checks an XOR checksum, returns a status byte, then releases the CPU.
- Sits between receiver/sender and inst_fetch's instruction memory write port.
- Drives the CPU pipeline reset: the pipeline is held in reset except in RUN.

---
 rtl/boot_pkg.sv | 30 +++
 rtl/boot_byte_assembler.sv | 45 ++++
 rtl/boot_loader_sequencer.sv | 168 ++++++++++++++++
 tb/tb_boot_loader_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
//==============================================================================
// Module      : boot_pkg
// Description : Shared types and constants for the UART boot loader sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_ACK  = 3'd4,
        ST_RUN  = 3'd5,
        ST_ERR  = 3'd6
    } boot_state_t;

    localparam logic [7:0] c_ack_ok_default = 8'hAA;
    localparam logic [7:0] c_ack_ng_default = 8'h55;

    localparam int c_byte_w         = 8;
    localparam int c_word_w         = 32;
    localparam int c_bytes_per_word = c_word_w / c_byte_w;
    localparam int c_byte_idx_w     = $clog2(c_bytes_per_word);

endpackage : boot_pkg

`default_nettype wire

// File: rtl/boot_byte_assembler.sv
//==============================================================================
// Module      : boot_byte_assembler
// Description : Big-endian 4-byte word shifter with byte index and running XOR.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module boot_byte_assembler
    import boot_pkg::*;
(
    input  logic                CLK,
    input  logic                reset,
    input  logic                clear,
    input  logic                byte_valid,
    input  logic [c_byte_w-1:0] byte_in,
    output logic [c_word_w-1:0] word_next,
    output logic                word_last,
    output logic [c_byte_w-1:0] csum
);

    logic [c_word_w-1:0]     r_word;
    logic [c_byte_idx_w-1:0] r_idx;
    logic [c_byte_w-1:0]     r_csum;

    // Word and "last byte" are exposed combinationally so the owner can act
    // in the same cycle as the final byte's strobe.
    assign word_next = {r_word[c_word_w-c_byte_w-1:0], byte_in};
    assign word_last = byte_valid && (r_idx == c_byte_idx_w'(c_bytes_per_word - 1));
    assign csum      = r_csum;

    always_ff @(posedge CLK) begin
        if (reset || clear) begin
            r_word <= '0;
            r_idx  <= '0;
            r_csum <= '0;
        end else if (byte_valid) begin
            r_word <= word_next;
            r_idx  <= r_idx + 1'b1;
            r_csum <= r_csum ^ byte_in;
        end
    end

endmodule : boot_byte_assembler

`default_nettype wire

// File: rtl/boot_loader_sequencer.sv
//==============================================================================
// Module      : boot_loader_sequencer
// Description : Loads a framed UART image into instruction memory, acks, then
//               releases the CPU pipeline reset.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module boot_loader_sequencer
    import boot_pkg::*;
#(
    parameter int         INST_MEM_WIDTH = 2,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] ACK_OK         = c_ack_ok_default,
    parameter logic [7:0] ACK_NG         = c_ack_ng_default
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      start_req,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [7:0]                tx_data,
    output logic                      tx_enable,
    input  logic                      tx_ready,
    output logic                      imem_we,
    output logic [INST_MEM_WIDTH-1:0] imem_addr,
    output logic [31:0]               imem_wdata,
    output logic                      cpu_reset,
    output logic                      loading,
    output logic                      error
);

    localparam logic [31:0] c_capacity = 32'(2 ** INST_MEM_WIDTH);
    localparam int          c_tmo_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

    boot_state_t               r_state;
    logic                      r_start_d;
    logic [INST_MEM_WIDTH:0]   r_n_words;
    logic [INST_MEM_WIDTH:0]   r_word_cnt;
    logic [c_tmo_w-1:0]        r_tmo_cnt;
    logic                      r_tmo_armed;
    logic                      r_ack_pass;
    logic [7:0]                r_tx_data;
    logic                      r_imem_we;
    logic [INST_MEM_WIDTH-1:0] r_imem_addr;
    logic [31:0]               r_imem_wdata;

    logic        w_start_rise;
    logic        w_start_ok;
    logic        w_asm_valid;
    logic [31:0] w_word_next;
    logic        w_word_last;
    logic [7:0]  w_csum;

    assign w_start_rise = start_req && !r_start_d;
    assign w_start_ok   = w_start_rise &&
                          (r_state inside {ST_IDLE, ST_RUN, ST_ERR});
    // The checksum byte itself must not fold into the running XOR.
    assign w_asm_valid  = rx_valid && (r_state inside {ST_HDR, ST_DATA});

    boot_byte_assembler u_asm (
        .CLK        (CLK),
        .reset      (reset),
        .clear      (w_start_ok),
        .byte_valid (w_asm_valid),
        .byte_in    (rx_data),
        .word_next  (w_word_next),
        .word_last  (w_word_last),
        .csum       (w_csum)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_start_d    <= 1'b0;
            r_n_words    <= '0;
            r_word_cnt   <= '0;
            r_tmo_cnt    <= '0;
            r_tmo_armed  <= 1'b0;
            r_ack_pass   <= 1'b0;
            r_tx_data    <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
        end else begin
            r_start_d <= start_req;
            r_imem_we <= 1'b0;

            case (r_state)
                ST_IDLE, ST_RUN, ST_ERR: begin
                    if (w_start_ok) begin
                        r_state     <= ST_HDR;
                        r_word_cnt  <= '0;
                        r_tmo_cnt   <= '0;
                        r_tmo_armed <= 1'b0;
                    end
                end

                ST_HDR, ST_DATA, ST_CSUM: begin
                    // Idle timer only runs once the first header byte has arrived.
                    if (rx_valid) begin
                        r_tmo_cnt   <= '0;
                        r_tmo_armed <= 1'b1;
                    end else if (r_tmo_armed) begin
                        if (r_tmo_cnt == c_tmo_last) begin
                            r_state    <= ST_ACK;
                            r_ack_pass <= 1'b0;
                            r_tx_data  <= ACK_NG;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        end
                    end

                    if (r_state == ST_HDR && w_word_last) begin
                        r_n_words <= w_word_next[INST_MEM_WIDTH:0];
                        if (w_word_next > c_capacity) begin
                            r_state    <= ST_ACK;
                            r_ack_pass <= 1'b0;
                            r_tx_data  <= ACK_NG;
                        end else if (w_word_next == 32'd0) begin
                            r_state <= ST_CSUM;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end

                    if (r_state == ST_DATA && w_word_last) begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_word_cnt[INST_MEM_WIDTH-1:0];
                        r_imem_wdata <= w_word_next;
                        r_word_cnt   <= r_word_cnt + 1'b1;
                        if (r_word_cnt + 1'b1 == r_n_words) begin
                            r_state <= ST_CSUM;
                        end
                    end

                    if (r_state == ST_CSUM && rx_valid) begin
                        r_state    <= ST_ACK;
                        r_ack_pass <= (rx_data == w_csum);
                        r_tx_data  <= (rx_data == w_csum) ? ACK_OK : ACK_NG;
                    end
                end

                ST_ACK: begin
                    if (tx_ready) begin
                        r_state <= r_ack_pass ? ST_RUN : ST_ERR;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Status strobe fires on the first ACK cycle the sender reports idle.
    assign tx_enable  = (r_state == ST_ACK) && tx_ready;
    assign tx_data    = r_tx_data;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign cpu_reset  = (r_state != ST_RUN);
    assign loading    = r_state inside {ST_HDR, ST_DATA, ST_CSUM, ST_ACK};
    assign error      = (r_state == ST_ERR);

endmodule : boot_loader_sequencer

`default_nettype wire

// File: tb/tb_boot_loader_sequencer.sv
//==============================================================================
// Module      : tb_boot_loader_sequencer
// Description : Randomized self-checking bench with a frame-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_boot_loader_sequencer;

    localparam int         INST_MEM_WIDTH = 2;
    localparam int         TIMEOUT_CYCLES = 16;
    localparam int         CAP            = 2 ** INST_MEM_WIDTH;
    localparam logic [7:0] ACK_OK         = 8'hAA;
    localparam logic [7:0] ACK_NG         = 8'h55;

    typedef logic [7:0] bq_t[$];

    logic                      CLK = 1'b0;
    logic                      reset = 1'b1;
    logic                      start_req = 1'b0;
    logic [7:0]                rx_data = '0;
    logic                      rx_valid = 1'b0;
    logic [7:0]                tx_data;
    logic                      tx_enable;
    logic                      tx_ready = 1'b1;
    logic                      imem_we;
    logic [INST_MEM_WIDTH-1:0] imem_addr;
    logic [31:0]               imem_wdata;
    logic                      cpu_reset;
    logic                      loading;
    logic                      error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [INST_MEM_WIDTH-1:0] wa_q[$];
    logic [31:0]               wd_q[$];
    logic [7:0]                tx_q[$];

    boot_loader_sequencer #(
        .INST_MEM_WIDTH (INST_MEM_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .ACK_OK         (ACK_OK),
        .ACK_NG         (ACK_NG)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .start_req  (start_req),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_enable  (tx_enable),
        .tx_ready   (tx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .loading    (loading),
        .error      (error)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (imem_we) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
        end
        if (tx_enable) tx_q.push_back(tx_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " tx_enable"},  32'(tx_enable),  32'd0);
        check_eq({tag, " tx_data"},    32'(tx_data),    32'd0);
        check_eq({tag, " imem_we"},    32'(imem_we),    32'd0);
        check_eq({tag, " imem_addr"},  32'(imem_addr),  32'd0);
        check_eq({tag, " imem_wdata"}, imem_wdata,      32'd0);
        check_eq({tag, " cpu_reset"},  32'(cpu_reset),  32'd1);
        check_eq({tag, " loading"},    32'(loading),    32'd0);
        check_eq({tag, " error"},      32'(error),      32'd0);
    endtask

    // Reference: parse the frame as a whole and predict writes and status.
    task automatic run_frame(input bq_t fr, input string tag);
        int          n;
        int          waited;
        bit          exp_ok;
        logic [7:0]  x;
        logic [31:0] exp_words[$];
        n = int'({fr[0], fr[1], fr[2], fr[3]});
        exp_ok = 1'b0;
        if (n <= CAP) begin
            x = 8'h00;
            for (int i = 0; i < 4 + 4 * n; i++) x ^= fr[i];
            for (int i = 0; i < n; i++)
                exp_words.push_back({fr[4+4*i], fr[5+4*i], fr[6+4*i], fr[7+4*i]});
            exp_ok = (fr[4 + 4 * n] == x);
        end
        wa_q.delete();
        wd_q.delete();
        tx_q.delete();
        pulse_start();
        foreach (fr[i]) send_byte(fr[i], $urandom_range(0, 2));
        waited = 0;
        while (tx_q.size() == 0 && waited < 40) begin
            tick();
            waited++;
        end
        repeat (3) tick();
        check_eq({tag, " tx count"}, 32'(tx_q.size()), 32'd1);
        if (tx_q.size() > 0)
            check_eq({tag, " tx_data"}, 32'(tx_q[0]), exp_ok ? 32'(ACK_OK) : 32'(ACK_NG));
        check_eq({tag, " write count"}, 32'(wa_q.size()), 32'(exp_words.size()));
        for (int i = 0; i < exp_words.size() && i < wa_q.size(); i++) begin
            check_eq({tag, " addr"}, 32'(wa_q[i]), 32'(i));
            check_eq({tag, " wdata"}, wd_q[i], exp_words[i]);
        end
        check_eq({tag, " cpu_reset"}, 32'(cpu_reset), exp_ok ? 32'd0 : 32'd1);
        check_eq({tag, " error"},     32'(error),     exp_ok ? 32'd0 : 32'd1);
        check_eq({tag, " loading"},   32'(loading),   32'd0);
    endtask

    function automatic bq_t rand_frame(input int n, input bit corrupt);
        bq_t         fr;
        logic [7:0]  x;
        logic [31:0] hdr;
        hdr = 32'(n);
        for (int i = 3; i >= 0; i--) fr.push_back(hdr[8*i +: 8]);
        if (n > CAP) begin
            fr.push_back(8'($urandom));
            return fr;
        end
        for (int i = 0; i < 4 * n; i++) fr.push_back(8'($urandom));
        x = 8'h00;
        foreach (fr[i]) x ^= fr[i];
        if (corrupt) x ^= 8'($urandom_range(1, 255));
        fr.push_back(x);
        return fr;
    endfunction

    initial begin
        bq_t fr;
        bit  saw_early;

        repeat (2) tick();
        do_reset();
        check_reset_outputs("reset");

        fr = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
               8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h02};
        run_frame(fr, "normal");

        fr[12] = 8'hFF;
        run_frame(fr, "badcsum");
        pulse_start();
        check_eq("err cleared", 32'(error), 32'd0);
        check_eq("err reload cpu_reset", 32'(cpu_reset), 32'd1);
        do_reset();

        fr = '{8'h00, 8'h00, 8'h00, 8'h05, 8'h11};
        run_frame(fr, "overflow");

        fr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(fr, "nzero");

        // Timeout with sender busy for a while
        tx_q.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        tx_ready  = 1'b0;
        saw_early = 1'b0;
        repeat (TIMEOUT_CYCLES + 10) begin
            tick();
            if (tx_enable) saw_early = 1'b1;
        end
        check_eq("timeout tx waits", 32'(saw_early), 32'd0);
        check_eq("timeout loading", 32'(loading), 32'd1);
        tx_ready = 1'b1;
        repeat (4) tick();
        check_eq("timeout tx count", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() > 0) check_eq("timeout tx_data", 32'(tx_q[0]), 32'(ACK_NG));
        check_eq("timeout error", 32'(error), 32'd1);
        check_eq("timeout cpu_reset", 32'(cpu_reset), 32'd1);

        // Reset mid-DATA, then a clean reload
        pulse_start();
        fr = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
        foreach (fr[i]) send_byte(fr[i], 0);
        do_reset();
        check_reset_outputs("midreset");
        fr = rand_frame(2, 1'b0);
        run_frame(fr, "reload");
        pulse_start();
        check_eq("run restart cpu_reset", 32'(cpu_reset), 32'd1);
        check_eq("run restart loading", 32'(loading), 32'd1);
        do_reset();

        for (int k = 0; k < 12; k++) begin
            fr = rand_frame($urandom_range(0, CAP + 1), ($urandom_range(0, 3) == 0));
            run_frame(fr, $sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_boot_loader_sequencer

`default_nettype wire
